// File: rtl/conv_window_mac.sv
// ============================================================================
// Module   : conv_window_mac
// Purpose  : p_rows x p_cols window multiply-accumulate with round/shift/saturate.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_window_mac #(
   parameter int p_dataBits = 8,
   parameter int p_rows     = 3,
   parameter int p_cols     = 3,
   parameter int p_coefBits = 8,
   parameter int p_shift    = 4,
   localparam int c_n       = p_rows * p_cols,
   localparam int c_addrW   = (c_n > 1) ? $clog2(c_n) : 1
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic [c_n*p_dataBits-1:0]      window_in,
   input  logic                           valid_in,
   input  logic                           sof_in,
   output logic                           busy_out,
   input  logic                           coef_we,
   input  logic [c_addrW-1:0]             coef_addr,
   input  logic [p_coefBits-1:0]          coef_data,
   output logic [p_dataBits-1:0]          data_out,
   output logic                           valid_out,
   output logic                           sof_out,
   input  logic                           busy_in
);

   localparam int c_prodW  = p_dataBits + p_coefBits + 1;
   localparam int c_accW   = c_prodW + $clog2(c_n);
   localparam int c_centre = c_n / 2;
   localparam int c_pixMax = (1 << p_dataBits) - 1;

   localparam logic signed [p_coefBits-1:0] c_unity  = p_coefBits'(1 << p_shift);
   localparam logic signed [c_accW:0]       c_round  = (p_shift > 0) ? (c_accW+1)'(1 << (p_shift-1)) : '0;
   localparam logic signed [c_accW:0]       c_satMax = (c_accW+1)'(c_pixMax);

   logic signed [p_coefBits-1:0] r_coef [c_n];
   logic signed [c_prodW-1:0]    w_prod [c_n];
   logic signed [c_prodW-1:0]    r_prod [c_n];
   logic signed [c_accW-1:0]     w_row  [p_rows];
   logic signed [c_accW-1:0]     r_row  [p_rows];
   logic signed [c_accW-1:0]     w_total;
   logic signed [c_accW:0]       w_rnd;
   logic signed [c_accW:0]       w_shifted;
   logic [p_dataBits-1:0]        w_sat;

   logic r_v1, r_v2, r_v3;
   logic r_sof1, r_sof2, r_sof3;
   logic [p_dataBits-1:0] r_data;

   assign busy_out  = busy_in;
   assign data_out  = r_data;
   assign valid_out = r_v3;
   assign sof_out   = r_sof3;

   // Coefficient bank: writable at any time, including stalls; out-of-range
   // addresses are dropped.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < c_n; k++) begin
            r_coef[k] <= (k == c_centre) ? c_unity : '0;
         end
      end else if (coef_we && (32'(coef_addr) < c_n)) begin
         r_coef[coef_addr] <= coef_data;
      end
   end

   for (genvar k = 0; k < c_n; k++) begin : g_prod
      logic signed [c_prodW-1:0] w_pix;
      logic signed [c_prodW-1:0] w_cf;
      assign w_pix     = {{(p_coefBits+1){1'b0}}, window_in[k*p_dataBits +: p_dataBits]};
      assign w_cf      = {{(p_dataBits+1){r_coef[k][p_coefBits-1]}}, r_coef[k]};
      assign w_prod[k] = w_pix * w_cf;
   end

   always_comb begin
      for (int r = 0; r < p_rows; r++) begin
         w_row[r] = '0;
         for (int c = 0; c < p_cols; c++) begin
            w_row[r] = w_row[r]
                     + {{(c_accW-c_prodW){r_prod[r*p_cols+c][c_prodW-1]}}, r_prod[r*p_cols+c]};
         end
      end
   end

   always_comb begin
      w_total = '0;
      for (int r = 0; r < p_rows; r++) begin
         w_total = w_total + r_row[r];
      end
      w_rnd     = {w_total[c_accW-1], w_total} + c_round;
      w_shifted = w_rnd >>> p_shift;
      if (w_shifted[c_accW]) begin
         w_sat = '0;
      end else if (w_shifted > c_satMax) begin
         w_sat = '1;
      end else begin
         w_sat = w_shifted[p_dataBits-1:0];
      end
   end

   // Single global stall: every stage holds while busy_in is high.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_v1   <= 1'b0;
         r_v2   <= 1'b0;
         r_v3   <= 1'b0;
         r_sof1 <= 1'b0;
         r_sof2 <= 1'b0;
         r_sof3 <= 1'b0;
         r_data <= '0;
         for (int k = 0; k < c_n; k++) begin
            r_prod[k] <= '0;
         end
         for (int r = 0; r < p_rows; r++) begin
            r_row[r] <= '0;
         end
      end else if (!busy_in) begin
         r_v1   <= valid_in;
         r_sof1 <= sof_in;
         r_v2   <= r_v1;
         r_sof2 <= r_sof1;
         r_v3   <= r_v2;
         r_sof3 <= r_sof2;
         r_data <= w_sat;
         r_prod <= w_prod;
         r_row  <= w_row;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_conv_window_mac.sv
// ============================================================================
// Module   : tb_conv_window_mac
// Purpose  : Self-checking bench for conv_window_mac against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv_window_mac;

   localparam int D  = 8;
   localparam int N  = 9;
   localparam int CB = 8;
   localparam int SH = 4;
   localparam int AW = 4;

   logic           i_clk = 1'b0;
   logic           i_rst_n;
   logic [N*D-1:0] window_in;
   logic           valid_in, sof_in, busy_out, coef_we, busy_in;
   logic [AW-1:0]  coef_addr;
   logic [CB-1:0]  coef_data;
   logic [D-1:0]   data_out;
   logic           valid_out, sof_out;

   always #5 i_clk = ~i_clk;

   conv_window_mac dut (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .window_in (window_in),
      .valid_in  (valid_in),
      .sof_in    (sof_in),
      .busy_out  (busy_out),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .data_out  (data_out),
      .valid_out (valid_out),
      .sof_out   (sof_out),
      .busy_in   (busy_in)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   int   tb_coef [N];
   logic [D:0] q_exp [$];
   logic [D:0] q_obs [$];
   bit   adv = 1'b0;

   // Filter output as plain integer arithmetic over the current kernel.
   function automatic int model_pixel(input logic [N*D-1:0] w);
      int total;
      total = 0;
      for (int k = 0; k < N; k++) total += int'(w[k*D +: D]) * tb_coef[k];
      total = (total + ((SH > 0) ? (1 << (SH-1)) : 0)) >>> SH;
      if (total < 0) total = 0;
      if (total > 255) total = 255;
      return total;
   endfunction

   function automatic logic [N*D-1:0] make_win(input logic [D-1:0] centre, input logic [D-1:0] other);
      logic [N*D-1:0] w;
      for (int k = 0; k < N; k++) w[k*D +: D] = (k == N/2) ? centre : other;
      return w;
   endfunction

   // Scoreboard feed: expected results at acceptance, observed results on each advance.
   always @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int k = 0; k < N; k++) tb_coef[k] = (k == N/2) ? (1 << SH) : 0;
         q_exp.delete();
         q_obs.delete();
         adv = 1'b0;
      end else begin
         if (valid_in && !busy_in) q_exp.push_back({sof_in, D'(model_pixel(window_in))});
         if (coef_we && coef_addr < N) tb_coef[coef_addr] = $signed(coef_data);
         adv = !busy_in;
      end
   end

   always @(negedge i_clk) begin
      if (adv && valid_out) q_obs.push_back({sof_out, data_out});
   end

   task automatic set_coef(input int a, input int d);
      coef_we   = 1'b1;
      coef_addr = AW'(a);
      coef_data = CB'(d);
      @(negedge i_clk);
      coef_we   = 1'b0;
   endtask

   task automatic set_all(input int d);
      for (int k = 0; k < N; k++) set_coef(k, d);
   endtask

   task automatic send_beat(input logic [N*D-1:0] w, input logic s);
      window_in = w;
      sof_in    = s;
      valid_in  = 1'b1;
      @(negedge i_clk);
      valid_in  = 1'b0;
      sof_in    = 1'b0;
   endtask

   task automatic drain();
      valid_in = 1'b0;
      sof_in   = 1'b0;
      busy_in  = 1'b0;
      repeat (6) @(negedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rst_n   = 1'b0;
      valid_in  = 1'b1;
      window_in = '1;
      repeat (3) begin
         @(negedge i_clk);
         n_checks++;
         if ({data_out, valid_out, sof_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got data=%h valid=%b sof=%b, expected 00/0/0", data_out, valid_out, sof_out);
         end
      end
      i_rst_n  = 1'b1;
      valid_in = 1'b0;
      @(negedge i_clk);
      send_beat(make_win(8'h5A, 8'hFF), 1'b1);
      for (int c = 1; c <= 2; c++) begin
         n_checks++;
         if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early cycle %0d: got valid_out=%b, expected 0", c, valid_out);
         end
         @(negedge i_clk);
      end
      n_checks++;
      if ({valid_out, sof_out, data_out} !== {1'b1, 1'b1, 8'h5A}) begin
         n_fail++;
         $display("FAIL identity_beat: got valid=%b sof=%b data=%h, expected 1/1/5a", valid_out, sof_out, data_out);
      end
      drain();
   endtask

   task automatic test_box();
      q_obs.delete();
      q_exp.delete();
      set_all(2);
      send_beat(make_win(8'h80, 8'h80), 1'b0);
      drain();
      n_checks++;
      if (q_obs.size() !== 1 || q_obs[0] !== {1'b0, 8'h90}) begin
         n_fail++;
         $display("FAIL box_kernel: got %0d results first=%h, expected 1 result 090", q_obs.size(), (q_obs.size() > 0) ? q_obs[0] : 9'h0);
      end
   endtask

   task automatic test_saturation();
      q_obs.delete();
      q_exp.delete();
      set_all(8'h7F);
      send_beat(make_win(8'hFF, 8'hFF), 1'b0);
      set_all(8'h80);
      send_beat(make_win(8'hFF, 8'hFF), 1'b1);
      drain();
      n_checks++;
      if (q_obs.size() !== 2) begin
         n_fail++;
         $display("FAIL sat_count: got %0d results, expected 2", q_obs.size());
      end else begin
         n_checks++;
         if (q_obs[0] !== {1'b0, 8'hFF}) begin
            n_fail++;
            $display("FAIL sat_high: got %h, expected 0ff", q_obs[0]);
         end
         n_checks++;
         if (q_obs[1] !== {1'b1, 8'h00}) begin
            n_fail++;
            $display("FAIL sat_low: got %h, expected 100", q_obs[1]);
         end
      end
      set_all(0);
      set_coef(N/2, 1 << SH);
   endtask

   task automatic test_backpressure();
      logic [D+1:0] saved;
      int cyc;
      int i;
      q_obs.delete();
      q_exp.delete();
      cyc = 0;
      i = 0;
      saved = '0;
      while (i < 10 && cyc < 100) begin
         if (cyc > 0 && !adv) begin
            n_checks++;
            if ({valid_out, sof_out, data_out} !== saved) begin
               n_fail++;
               $display("FAIL stall_frozen cycle %0d: got %h, expected %h", cyc, {valid_out, sof_out, data_out}, saved);
            end
         end
         saved     = {valid_out, sof_out, data_out};
         busy_in   = (cyc >= 4 && cyc <= 7);
         valid_in  = 1'b1;
         sof_in    = (i == 0);
         window_in = make_win(D'(16 + i), D'($urandom));
         #1;
         n_checks++;
         if (busy_out !== busy_in) begin
            n_fail++;
            $display("FAIL busy_mirror cycle %0d: got %b, expected %b", cyc, busy_out, busy_in);
         end
         @(negedge i_clk);
         if (!busy_in) i++;
         cyc++;
      end
      drain();
      n_checks++;
      if (q_obs.size() !== 10) begin
         n_fail++;
         $display("FAIL bp_count: got %0d results, expected 10", q_obs.size());
      end
      for (int k = 0; k < q_obs.size() && k < 10; k++) begin
         n_checks++;
         if (q_obs[k] !== {(k == 0), D'(16 + k)}) begin
            n_fail++;
            $display("FAIL bp_order[%0d]: got %h, expected %h", k, q_obs[k], {(k == 0), D'(16 + k)});
         end
      end
   endtask

   task automatic test_coef_change();
      logic [D:0] want [3];
      want[0] = {1'b0, 8'h30};
      want[1] = {1'b0, 8'h60};
      want[2] = {1'b0, 8'h60};
      q_obs.delete();
      q_exp.delete();
      window_in = make_win(8'h30, 8'h11);
      valid_in  = 1'b1;
      coef_we   = 1'b1;
      coef_addr = 4'd4;
      coef_data = 8'h20;
      @(negedge i_clk);
      coef_addr = 4'd12;
      coef_data = 8'h7F;
      @(negedge i_clk);
      coef_we   = 1'b0;
      @(negedge i_clk);
      valid_in  = 1'b0;
      drain();
      n_checks++;
      if (q_obs.size() !== 3) begin
         n_fail++;
         $display("FAIL coef_count: got %0d results, expected 3", q_obs.size());
      end
      for (int k = 0; k < q_obs.size() && k < 3; k++) begin
         n_checks++;
         if (q_obs[k] !== want[k]) begin
            n_fail++;
            $display("FAIL coef_change[%0d]: got %h, expected %h", k, q_obs[k], want[k]);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_coef(4, 8'h40);
      for (int k = 0; k < 3; k++) begin
         window_in = make_win(D'(8'h20 + k), 8'h00);
         valid_in  = 1'b1;
         @(negedge i_clk);
      end
      valid_in = 1'b0;
      i_rst_n  = 1'b0;
      repeat (2) @(negedge i_clk);
      i_rst_n  = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         n_checks++;
         if (valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flush cycle %0d: got valid_out=%b, expected 0", c, valid_out);
         end
      end
      send_beat(make_win(8'h44, 8'h00), 1'b0);
      drain();
      n_checks++;
      if (q_obs.size() !== 1 || q_obs[0] !== {1'b0, 8'h44}) begin
         n_fail++;
         $display("FAIL reset_identity: got %0d results first=%h, expected 1 result 044", q_obs.size(), (q_obs.size() > 0) ? q_obs[0] : 9'h0);
      end
   endtask

   task automatic test_random_stream();
      q_obs.delete();
      q_exp.delete();
      for (int c = 0; c < 400; c++) begin
         busy_in  = ($urandom_range(0, 3) == 0);
         valid_in = ($urandom_range(0, 2) != 0);
         sof_in   = $urandom_range(0, 1) == 1;
         for (int k = 0; k < N; k++) window_in[k*D +: D] = D'($urandom);
         coef_we   = ($urandom_range(0, 7) == 0);
         coef_addr = AW'($urandom_range(0, 15));
         coef_data = CB'(int'($urandom_range(0, 12)) - 4);
         @(negedge i_clk);
      end
      coef_we = 1'b0;
      drain();
      n_checks++;
      if (q_obs.size() !== q_exp.size()) begin
         n_fail++;
         $display("FAIL rand_count: got %0d results, expected %0d", q_obs.size(), q_exp.size());
      end
      for (int k = 0; k < q_obs.size() && k < q_exp.size(); k++) begin
         n_checks++;
         if (q_obs[k] !== q_exp[k]) begin
            n_fail++;
            $display("FAIL rand_result[%0d]: got %h, expected %h", k, q_obs[k], q_exp[k]);
         end
      end
   endtask

   initial begin
      i_rst_n   = 1'b0;
      window_in = '0;
      valid_in  = 1'b0;
      sof_in    = 1'b0;
      busy_in   = 1'b0;
      coef_we   = 1'b0;
      coef_addr = '0;
      coef_data = '0;
      test_reset();
      test_box();
      test_saturation();
      test_backpressure();
      test_coef_change();
      test_reset_mid();
      test_random_stream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

`default_nettype wire

// File: doc/conv_window_mac.md
Name: conv_window_mac

Overview:
- Downstream neighbour of the sequential-to-parallel window stage.
- Consumes one p_rows x p_cols pixel window per accepted beat and multiplies each pixel by a programmable signed coefficient.
- Sums the products, then rounds, shifts and saturates the sum back to one p_dataBits unsigned pixel.
- Uses the same valid/sof/busy streaming handshake as its neighbours; fixed 3-stage pipeline.

Parameters:
- p_dataBits, 8: pixel width, unsigned.
- p_rows, 3: window rows.
- p_cols, 3: window columns.
- p_coefBits, 8: coefficient width, signed two's complement.
- p_shift, 4: right shift applied to the sum; also the fractional bits of the coefficients.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  synchronous reset, active-low.
- window_in  in  p_rows*p_cols*p_dataBits  window; element k = r*p_cols+c at bits [k*p_dataBits +: p_dataBits].
- valid_in  in  1  window_in valid.
- sof_in  in  1  start of frame, qualified by valid_in.
- busy_out  out  1  upstream must hold its data while high.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(p_rows*p_cols)  coefficient index k.
- coef_data  in  p_coefBits  coefficient value.
- data_out  out  p_dataBits  filtered pixel.
- valid_out  out  1  data_out valid.
- sof_out  out  1  sof aligned with data_out.
- busy_in  in  1  downstream stall.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - All stage valid flags clear; data_out=0, valid_out=0, sof_out=0.
  - Coefficients load the identity kernel: index floor(N/2) = 1<<p_shift, all others 0 (N = p_rows*p_cols).
  - Reset asserted mid-stream discards all in-flight beats; none reappear afterwards.
- Stall and handshake:
  - busy_out = busy_in, combinational (global stall).
  - While busy_in=1, every pipeline register (data, valid, sof) holds, and data_out/valid_out/sof_out stay stable.
  - A beat is accepted when valid_in=1 and busy_in=0.
  - Bubbles (valid_in=0 with busy_in=0) advance through the pipeline as invalid stages.
- Stage 1: register the N signed products pixel_k * coef_k. Pixels are zero-extended. Product width is p_dataBits+p_coefBits+1. The stage's valid/sof are registered from valid_in/sof_in.
- Stage 2: register the per-row partial sums, each p_cols products.
- Stage 3:
  - Total = sum of the row sums, held in an accumulator of width p_dataBits+p_coefBits+1+clog2(N). No overflow is possible.
  - Rounding: add 1<<(p_shift-1) when p_shift>0, then arithmetic shift right by p_shift.
  - Saturation: negative results give 0; results above 2^p_dataBits-1 give 2^p_dataBits-1.
  - Register the result to data_out.
- Latency: the accepted beat appears at valid_out exactly 3 unstalled cycles after acceptance.
- sof: travels with its beat, unmodified; sof_out is only meaningful when valid_out=1.
- Coefficient writes:
  - Taken on any clock with coef_we=1, including during a stall.
  - A write on edge t is used by beats entering stage 1 on edge t+1 and later; beats already in the pipeline are unaffected.
  - coef_addr >= N is ignored.
- Simultaneous coef_we and an accepted beat on the same edge: the beat uses the old coefficient.
- The shadow-free coefficient update means software must stall or idle the stream to change the kernel atomically; this is documented, not enforced.

Test Plan:
- Reset with identity kernel; window centre=0x5A, others=0xFF, valid for 1 cycle -> after 3 cycles valid_out=1 with data_out=0x5A, sof_out follows sof_in; outputs 0 during reset.
- Box kernel: all coefs=2 (p_shift=4), all pixels=0x80 -> sum=2304, (2304+8)>>4=144 -> data_out=0x90.
- Saturation: all coefs=0x7F with pixels=0xFF -> data_out=0xFF; all coefs=0x80 (-128) -> data_out=0x00.
- Backpressure: stream 10 beats with incrementing centre pixel and identity kernel, busy_in high for cycles 4-7 -> busy_out mirrors busy_in; outputs frozen during the stall; all 10 results appear in order, none lost or duplicated.
- Coefficient change mid-stream: write coef 4 = 0x20 on the same edge as beat n -> beat n uses 0x10 (gain x1), beat n+1 uses gain x2 (centre 0x30 -> 0x60); coef_addr=12 write has no effect.
- Reset mid-operation with 3 beats in flight -> no valid_out after reset deasserts until new input; coefficients back to identity.
